// File: rtl/shift_rx_pkg.sv
// Shared types and defaults for the serial shift receiver.
package shift_rx_pkg;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RECV = 2'd1, S_HOLD = 2'd2} rx_state_t;
  localparam int DEFAULT_WIDTH = 8;
endpackage

// File: rtl/shift_receiver_if.sv
// Peer/consumer-facing signals of the shift receiver; master drives, slave receives.
interface shift_receiver_if import shift_rx_pkg::*; #(parameter int WIDTH = DEFAULT_WIDTH);
  localparam int CW = $clog2(WIDTH + 1);
  logic             Frame;
  logic             Shift_Strobe;
  logic             Shift_In;
  logic             Ack;
  logic             Clr_Err;
  logic [WIDTH-1:0] Data_Out;
  logic             Valid;
  logic             Busy;
  logic [CW-1:0]    Bit_Count;
  logic             Frame_Err;
  logic             Overrun;

  modport master (output Frame, Shift_Strobe, Shift_In, Ack, Clr_Err,
                  input  Data_Out, Valid, Busy, Bit_Count, Frame_Err, Overrun);
  modport slave  (input  Frame, Shift_Strobe, Shift_In, Ack, Clr_Err,
                  output Data_Out, Valid, Busy, Bit_Count, Frame_Err, Overrun);
endinterface

// File: rtl/shift_rx_sreg.sv
// Shift register with clear; nxt exposes the post-edge value so a word can be
// captured on the same edge as its final bit.
module shift_rx_sreg #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             clr,
  input  logic             en,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] nxt
);
  logic [WIDTH-1:0] base, shifted;

  // Clear and shift may coincide: the bit then lands in a zeroed register.
  assign base = clr ? '0 : q;

  generate
    if (MSB_FIRST) begin : g_left
      assign shifted = {base[WIDTH-2:0], sin};
    end else begin : g_right
      assign shifted = {sin, base[WIDTH-1:1]};
    end
  endgenerate

  assign nxt = en ? shifted : base;

  always_ff @(posedge Clk) begin
    if (Reset) q <= '0;
    else       q <= nxt;
  end
endmodule

// File: rtl/shift_receiver.sv
// Receives WIDTH-bit serial frames, hands words off via Valid/Ack, and keeps
// sticky flags for short frames, extra strobes and overruns.
module shift_receiver import shift_rx_pkg::*; #(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic            Clk,
  input  logic            Reset,
  shift_receiver_if.slave rx
);
  localparam int CW = $clog2(WIDTH + 1);

  rx_state_t        state, state_nxt;
  logic             frame_q, frame_rise, strb, clr, accept, last;
  logic             extra, short_frame, ovr_set, busy;
  logic [CW-1:0]    count, count_base;
  logic [WIDTH-1:0] sreg_q, sreg_nxt, data_q;
  logic             valid_q, ferr_q, ovr_q;

  assign frame_rise  = rx.Frame & ~frame_q;
  assign strb        = rx.Shift_Strobe & rx.Frame;
  assign clr         = (state == S_IDLE) & frame_rise;
  // A strobe coinciding with the frame's rising edge is already bit 0.
  assign accept      = strb & (clr | (state == S_RECV));
  assign count_base  = clr ? '0 : count;
  assign last        = accept & (count_base == CW'(WIDTH - 1));
  assign extra       = strb & (state == S_HOLD);
  assign short_frame = (state == S_RECV) & ~rx.Frame;
  assign ovr_set     = last & valid_q & ~rx.Ack;

  shift_rx_sreg #(.WIDTH(WIDTH), .MSB_FIRST(MSB_FIRST)) u_sreg (
    .Clk   (Clk),
    .Reset (Reset),
    .clr   (clr),
    .en    (accept),
    .sin   (rx.Shift_In),
    .q     (sreg_q),
    .nxt   (sreg_nxt)
  );

  always_ff @(posedge Clk) begin
    if (Reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (frame_rise) state_nxt = last ? S_HOLD : S_RECV;
      S_RECV: if (!rx.Frame)  state_nxt = S_IDLE;
              else if (last)  state_nxt = S_HOLD;
      S_HOLD: if (!rx.Frame)  state_nxt = S_IDLE;
      default:                state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == S_RECV);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      frame_q <= 1'b0;
      count   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      frame_q <= rx.Frame;
      if (accept && count_base != CW'(WIDTH)) count <= count_base + 1'b1;
      else                                    count <= count_base;
      if (last) begin
        data_q  <= sreg_nxt;
        valid_q <= 1'b1;
      end else if (rx.Ack) begin
        valid_q <= 1'b0;
      end
      // Set beats clear when both land in the same cycle.
      ferr_q <= (ferr_q & ~rx.Clr_Err) | short_frame | extra;
      ovr_q  <= (ovr_q  & ~rx.Clr_Err) | ovr_set;
    end
  end

  assign rx.Data_Out  = data_q;
  assign rx.Valid     = valid_q;
  assign rx.Busy      = busy;
  assign rx.Bit_Count = count;
  assign rx.Frame_Err = ferr_q;
  assign rx.Overrun   = ovr_q;
endmodule
